instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter WORDSIZE, default 64: PC and address width in bits.
REQ-002 Parameter INSTRUCTION_SIZE, default 32: instruction width in bits.
REQ-003 Parameter MEMORY_SIZE, default 1024: instruction-memory depth in words.
REQ-004 Parameter RESET_PC, default 0: byte address of the first fetch.
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-006 The block SHALL have these ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- imem_addr, out, WORDSIZE: word index to instruction memory, equal to pc >> 2.
- imem_instruction, in, INSTRUCTION_SIZE: instruction memory read data, combinational from imem_addr.
- redirect, in, 1: branch/jump taken this cycle.
- redirect_target, in, WORDSIZE: new byte PC.
- out_valid, out, 1: the output register holds an instruction.
- out_ready, in, 1: the decode stage accepts.
- out_instruction, out, INSTRUCTION_SIZE: fetched instruction.
- out_pc, out, WORDSIZE: byte PC of out_instruction.
- fetch_error, out, 1: sticky fault flag.

Function
REQ-007 FSM states SHALL be BOOT, RUN and HALT; reset enters BOOT.
REQ-008 BOOT SHALL last exactly one cycle with out_valid=0 and no capture, then go to RUN.
REQ-009 In RUN, a capture SHALL occur when (!out_valid || out_ready) && !redirect. A capture loads out_instruction=imem_instruction, sets out_pc=pc and out_valid=1, and updates pc=pc+4.
REQ-010 In RUN, with out_valid=1 and out_ready=0 and no redirect, pc and the output register SHALL hold unchanged (stall).
REQ-011 A redirect in RUN SHALL take priority over capture and acceptance. It sets pc=redirect_target and out_valid=0 (flush), and the next capture uses the new pc.
REQ-012 Fetch latency SHALL be one cycle: the instruction at pc appears on out_* the cycle after the capture edge.
REQ-013 Sustained throughput SHALL be one instruction per cycle while out_ready=1.
REQ-014 A redirect with redirect_target[1:0]!=0 SHALL set fetch_error=1, set out_valid=0 and enter HALT.
REQ-015 In RUN, if pc>>2 >= MEMORY_SIZE at a would-be capture, the block SHALL not capture, SHALL set fetch_error=1 and SHALL enter HALT.
REQ-016 In HALT, out_valid SHALL be 0, pc SHALL be frozen, and redirect and out_ready SHALL be ignored. Only reset exits HALT.
REQ-017 PC arithmetic SHALL be modulo 2^WORDSIZE, with no carry out. Wrap-around is caught by REQ-015.
REQ-018 imem_addr SHALL be a continuous function of the pc register only, with no combinational path from redirect or out_ready.

Reset
REQ-019 Asserting rst_n low SHALL immediately force state=BOOT, pc=RESET_PC, out_valid=0, out_instruction=0, out_pc=0 and fetch_error=0, including mid-stall or mid-redirect.
REQ-020 After rst_n deasserts, the first capture SHALL occur on the second rising edge.

Structure
REQ-021 The FSM state encoding, the PC increment (4) and the alignment mask SHALL live in a shared package riscv_pkg, which also holds the opcode constants.
REQ-022 The output register with valid/ready SHALL be a sub-module, fetch_out_reg (pipeline register with load/flush/hold). The PC and FSM SHALL stay in instruction_fetch.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, RESET_PC=0, out_ready=1 -> out_pc 0, 4, 8, 12 on consecutive cycles; out_instruction matches memory words 0..3; out_valid first high 2 edges after rst_n rises.
- out_ready=0 for 3 cycles while out_pc=4 -> out_pc and out_instruction stable at 4, imem_addr stays 2; on release, next out_pc=8.
- redirect=1, target=0x40, while out_valid=1 and out_ready=1 -> next cycle out_valid=0; the following cycle out_pc=0x40; the pre-redirect instruction is never accepted twice.
- redirect target=0x42 -> fetch_error=1, out_valid=0 permanently; redirect to 0x40 afterwards is ignored.
- MEMORY_SIZE=4, out_ready=1 -> out_pc 0, 4, 8, 12, then fetch_error=1 with no capture at pc=16.
- rst_n pulsed low mid-stall -> all outputs zero asynchronously (before the next edge); the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch FSM encoding, PC step, alignment mask and opcode constants
package riscv_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
    localparam int PC_INC = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: valid/ready pipeline register with load, flush and hold
module fetch_out_reg #(
    parameter int WORDSIZE = 64,
    parameter int INSTRUCTION_SIZE = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        flush,
    input  logic [INSTRUCTION_SIZE-1:0] in_instruction,
    input  logic [WORDSIZE-1:0]         in_pc,
    output logic                        valid,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic [WORDSIZE-1:0]         pc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= 1'b0;
            instruction <= '0;
            pc          <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid       <= 1'b1;
            instruction <= in_instruction;
            pc          <= in_pc;
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/FSM driving instruction memory into a valid/ready output register
module instruction_fetch import riscv_pkg::*; #(
    parameter int WORDSIZE = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int MEMORY_SIZE = 1024,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
    input  logic                        redirect,
    input  logic [WORDSIZE-1:0]         redirect_target,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTION_SIZE-1:0] out_instruction,
    output logic [WORDSIZE-1:0]         out_pc,
    output logic                        fetch_error
);
    fetch_state_t state;
    logic [WORDSIZE-1:0] pc;
    logic run, take, oob, bad_target, load, flush;
    assign run        = state == RUN;
    assign take       = (!out_valid || out_ready) && !redirect;
    assign oob        = (pc >> 2) >= WORDSIZE'(MEMORY_SIZE);
    assign bad_target = |(redirect_target[1:0] & ALIGN_MASK);
    assign load       = run && take && !oob;
    // entering HALT on an out-of-range fetch must also drop the held entry
    assign flush      = run && (redirect || (take && oob));
    assign imem_addr  = pc >> 2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_error <= 1'b0;
        end else if (state == BOOT) begin
            state <= RUN;
        end else if (run) begin
            if (redirect && bad_target) begin
                fetch_error <= 1'b1;
                state       <= HALT;
            end else if (redirect) begin
                pc <= redirect_target;
            end else if (take && oob) begin
                fetch_error <= 1'b1;
                state       <= HALT;
            end else if (take) begin
                pc <= pc + WORDSIZE'(PC_INC);
            end
        end
    end
    fetch_out_reg #(.WORDSIZE(WORDSIZE), .INSTRUCTION_SIZE(INSTRUCTION_SIZE)) u_out (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .flush(flush),
        .in_instruction(imem_instruction),
        .in_pc(pc),
        .valid(out_valid),
        .instruction(out_instruction),
        .pc(out_pc)
    );
endmodule
